aig_bist_compactor: RTL and testbench

- Self-test harness stage wrapped around one generated combinational benchmark netlist (2 inputs, 19 outputs).
- Upstream side: drives the netlist inputs with an exhaustive counting pattern sequence.
- Downstream side: consumes the netlist outputs and compacts them into a multiple-input signature register (MISR).
- Compares the final signature against an expected value, so the team can check benchmark netlists (original vs balanced) for equivalence in silicon or simulation.

---
 rtl/aig_bist_pkg.sv | 26 ++
 rtl/aig_misr.sv | 36 +++
 rtl/aig_bist_compactor.sv | 100 ++++++++++
 tb/tb_aig_bist_compactor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aig_bist_pkg.sv
// Shared types and constants for the AIG BIST compactor: FSM states, default
// MISR taps/seed and a reference MISR step function.
package aig_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          SIG_W    = 19;
  localparam logic [18:0] DEF_POLY = 19'h00027;
  localparam logic [18:0] DEF_SEED = 19'h00000;

  // One MISR step: shift left, fold the msb back through the taps, absorb resp.
  function automatic logic [SIG_W-1:0] misr_next(
    input logic [SIG_W-1:0] sig,
    input logic [SIG_W-1:0] resp,
    input logic [SIG_W-1:0] poly
  );
    logic [SIG_W-1:0] shifted;
    shifted = {sig[SIG_W-2:0], 1'b0};
    return shifted ^ (sig[SIG_W-1] ? poly : '0) ^ resp;
  endfunction

endpackage

// File: rtl/aig_misr.sv
// Multiple-input signature register: width and feedback taps parameterised,
// synchronous seed load takes priority over the compaction step.
module aig_misr #(
  parameter int         W    = 19,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] SEED = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] seed_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  always_comb begin
    sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else if (load_i) begin
      sig_q <= seed_i;
    end else if (en_i) begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/aig_bist_compactor.sv
// BIST wrapper: counts exhaustive input patterns into a combinational netlist
// and compacts its responses into a MISR, then compares against exp_sig_i.
module aig_bist_compactor
  import aig_bist_pkg::*;
#(
  parameter int              IN_W  = 2,
  parameter int              OUT_W = 19,
  parameter logic [OUT_W-1:0] POLY = DEF_POLY,
  parameter logic [OUT_W-1:0] SEED = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             hold_i,
  output logic [IN_W-1:0]  pat_o,
  input  logic [OUT_W-1:0] resp_i,
  input  logic [OUT_W-1:0] exp_sig_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] sig_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start_i is a level sampled only in IDLE/DONE; while RUN, hold_i
  // stalls both counter and MISR; done_o is a level held until the next start.

  localparam int              NPAT     = 1 << IN_W;
  localparam logic [IN_W:0]   PAT_LAST = (IN_W + 1)'(NPAT - 1);
  localparam logic [IN_W:0]   PAT_ONE  = (IN_W + 1)'(1);

  state_e        state_q, state_d;
  logic [IN_W:0] pat_q, pat_d;
  logic          misr_load;
  logic          misr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = RUN;
          pat_d     = '0;
          misr_load = 1'b1;
        end
      end
      RUN: begin
        if (!hold_i) begin
          misr_en = 1'b1;
          // The extra counter bit keeps this compare from ever aliasing on wrap.
          if (pat_q == PAT_LAST) begin
            state_d = DONE;
          end else begin
            pat_d = pat_q + PAT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pat_d   = '0;
      end
    endcase
  end

  aig_misr #(
    .W    (OUT_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (misr_load),
    .en_i   (misr_en),
    .seed_i (SEED),
    .din_i  (resp_i),
    .sig_o  (sig_o)
  );

  assign pat_o       = pat_q[IN_W-1:0];
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign pass_o      = done_o & (sig_o == exp_sig_i);
  assign fail_o      = done_o & (sig_o != exp_sig_i);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aig_bist_compactor.sv
// Self-checking bench for aig_bist_compactor; the netlist is a per-test
// response table indexed by pat_o, signatures come from an arithmetic model.
module tb_aig_bist_compactor;
  import aig_bist_pkg::*;

  localparam int          IN_W  = 2;
  localparam int          OUT_W = 19;
  localparam int          NPAT  = 4;
  localparam int unsigned MOD   = 32'h0008_0000;
  localparam int unsigned TAPS  = 32'h0000_0027;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             hold_i = 1'b0;
  logic [IN_W-1:0]  pat_o;
  logic [OUT_W-1:0] resp_i;
  logic [OUT_W-1:0] exp_sig_i = '0;
  logic             busy_o, done_o, pass_o, fail_o;
  logic [OUT_W-1:0] sig_o;
  logic [1:0]       dbg_state_o;

  logic [OUT_W-1:0] resp_tab [NPAT];
  logic             flip_en = 1'b0;
  logic [IN_W-1:0]  flip_pat = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in netlist: combinational table lookup, with an optional bit-0 fault.
  assign resp_i = resp_tab[pat_o] ^ {{(OUT_W-1){1'b0}}, (flip_en && pat_o == flip_pat)};

  aig_bist_compactor dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .hold_i      (hold_i),
    .pat_o       (pat_o),
    .resp_i      (resp_i),
    .exp_sig_i   (exp_sig_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sig_o       (sig_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .dbg_state_o (dbg_state_o)
  );

  // Reference signature from plain arithmetic: double, reduce mod 2^19 with taps.
  function automatic logic [OUT_W-1:0] model_sig(input int npat_used, input bit flip, input int fpat);
    int unsigned s;
    int unsigned r;
    s = 0;
    for (int p = 0; p < npat_used; p++) begin
      r = int'(resp_tab[p]);
      if (flip && p == fpat) r = r ^ 1;
      s = s * 2;
      if (s >= MOD) s = (s - MOD) ^ TAPS;
      s = s ^ r;
    end
    return OUT_W'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then wait for done_o; edges counts the start edge too.
  task automatic run_to_done(input int max_edges, output int edges, output bit timeout);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    edges = 1;
    while (!done_o && edges < max_edges) begin
      tick();
      edges++;
    end
    timeout = !done_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_vec++; if (pat_o !== 2'd0) begin n_err++; $display("FAIL reset_pat got %0h want 0", pat_o); end
    n_vec++; if (sig_o !== 19'h0) begin n_err++; $display("FAIL reset_sig got %05h want 00000", sig_o); end
    n_vec++; if ({busy_o, done_o, pass_o, fail_o} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 0000", {busy_o, done_o, pass_o, fail_o});
    end
    n_vec++; if (dbg_state_o !== 2'(IDLE)) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state_o); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b want 0", busy_o); end
  endtask

  task automatic test_zero_resp();
    int edges;
    for (int p = 0; p < NPAT; p++) resp_tab[p] = '0;
    exp_sig_i = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    edges = 1;
    for (int p = 0; p < NPAT; p++) begin
      n_vec++; if (pat_o !== IN_W'(p) || busy_o !== 1'b1) begin
        n_err++; $display("FAIL zero_pat_step got pat=%0d busy=%b want pat=%0d busy=1", pat_o, busy_o, p);
      end
      tick();
      edges++;
    end
    n_vec++; if (done_o !== 1'b1 || edges != 5) begin
      n_err++; $display("FAIL zero_latency got done=%b edges=%0d want done=1 edges=5", done_o, edges);
    end
    n_vec++; if (pat_o !== 2'd3) begin n_err++; $display("FAIL zero_pat_end got %0d want 3", pat_o); end
    n_vec++; if (sig_o !== 19'h0) begin n_err++; $display("FAIL zero_sig got %05h want 00000", sig_o); end
    n_vec++; if (pass_o !== 1'b1 || fail_o !== 1'b0) begin
      n_err++; $display("FAIL zero_pass got pass=%b fail=%b want 1/0", pass_o, fail_o);
    end
  endtask

  task automatic test_ones_resp();
    logic [OUT_W-1:0] want [NPAT];
    want[0] = 19'h7FFFF; want[1] = 19'h00026; want[2] = 19'h7FFB3; want[3] = 19'h000BE;
    for (int p = 0; p < NPAT; p++) resp_tab[p] = 19'h7FFFF;
    exp_sig_i = 19'h000BE;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int p = 0; p < NPAT; p++) begin
      tick();
      n_vec++; if (sig_o !== want[p]) begin
        n_err++; $display("FAIL ones_sig_step%0d got %05h want %05h", p, sig_o, want[p]);
      end
    end
    n_vec++; if (done_o !== 1'b1 || pass_o !== 1'b1 || fail_o !== 1'b0) begin
      n_err++; $display("FAIL ones_pass got done=%b pass=%b fail=%b want 1/1/0", done_o, pass_o, fail_o);
    end
    exp_sig_i = 19'h000BF;
    #1;
    n_vec++; if (pass_o !== 1'b0 || fail_o !== 1'b1) begin
      n_err++; $display("FAIL ones_fail got pass=%b fail=%b want 0/1", pass_o, fail_o);
    end
    tick();
    n_vec++; if (done_o !== 1'b1 || fail_o !== 1'b1) begin
      n_err++; $display("FAIL done_level got done=%b fail=%b want 1/1", done_o, fail_o);
    end
  endtask

  task automatic test_hold();
    int edges;
    logic [OUT_W-1:0] sig_snap;
    logic [IN_W-1:0]  pat_snap;
    for (int p = 0; p < NPAT; p++) resp_tab[p] = 19'h7FFFF;
    exp_sig_i = 19'h000BE;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    edges = 3;
    pat_snap = pat_o;
    sig_snap = sig_o;
    hold_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      edges++;
      n_vec++; if (pat_o !== pat_snap || sig_o !== sig_snap || busy_o !== 1'b1) begin
        n_err++; $display("FAIL hold_freeze got pat=%0d sig=%05h want pat=%0d sig=%05h", pat_o, sig_o, pat_snap, sig_snap);
      end
    end
    hold_i = 1'b0;
    while (!done_o && edges < 40) begin
      tick();
      edges++;
    end
    n_vec++; if (done_o !== 1'b1 || edges != 8) begin
      n_err++; $display("FAIL hold_latency got done=%b edges=%0d want done=1 edges=8", done_o, edges);
    end
    n_vec++; if (sig_o !== 19'h000BE || pass_o !== 1'b1) begin
      n_err++; $display("FAIL hold_sig got %05h pass=%b want 000BE pass=1", sig_o, pass_o);
    end
  endtask

  task automatic test_random_netlist();
    int edges;
    bit timeout;
    logic [OUT_W-1:0] want;
    for (int it = 0; it < 6; it++) begin
      for (int p = 0; p < NPAT; p++) resp_tab[p] = OUT_W'($urandom_range(0, 32'h7FFFF));
      want = model_sig(NPAT, 1'b0, 0);
      exp_sig_i = want;
      run_to_done(40, edges, timeout);
      n_vec++; if (timeout || sig_o !== want || pass_o !== 1'b1 || fail_o !== 1'b0) begin
        n_err++; $display("FAIL rand_sig it=%0d got %05h pass=%b timeout=%b want %05h pass=1", it, sig_o, pass_o, timeout, want);
      end
    end
    flip_en = 1'b1;
    flip_pat = 2'd2;
    run_to_done(40, edges, timeout);
    want = model_sig(NPAT, 1'b1, 2);
    n_vec++; if (timeout || fail_o !== 1'b1 || pass_o !== 1'b0 || sig_o !== want) begin
      n_err++; $display("FAIL rand_flip got sig=%05h fail=%b pass=%b want sig=%05h fail=1", sig_o, fail_o, pass_o, want);
    end
    flip_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    int edges;
    bit timeout;
    logic [OUT_W-1:0] want;
    for (int p = 0; p < NPAT; p++) resp_tab[p] = OUT_W'($urandom_range(1, 32'h7FFFF));
    want = model_sig(NPAT, 1'b0, 0);
    exp_sig_i = want;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if ({busy_o, done_o, pass_o, fail_o} !== 4'b0 || pat_o !== 2'd0 || sig_o !== 19'h0) begin
      n_err++; $display("FAIL midrst_async got flags=%b pat=%0d sig=%05h want 0000/0/00000",
        {busy_o, done_o, pass_o, fail_o}, pat_o, sig_o);
    end
    rst = 1'b0;
    tick();
    n_vec++; if (dbg_state_o !== 2'(IDLE) || done_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_idle got state=%0d done=%b want 0/0", dbg_state_o, done_o);
    end
    run_to_done(40, edges, timeout);
    n_vec++; if (timeout || edges != 5 || sig_o !== want || pass_o !== 1'b1) begin
      n_err++; $display("FAIL midrst_rerun got sig=%05h edges=%0d want %05h edges=5", sig_o, edges, want);
    end
  endtask

  task automatic test_start_held();
    logic [OUT_W-1:0] want;
    for (int p = 0; p < NPAT; p++) resp_tab[p] = OUT_W'($urandom_range(1, 32'h7FFFF));
    want = model_sig(NPAT, 1'b0, 0);
    exp_sig_i = want;
    start_i = 1'b1;
    tick();
    for (int p = 0; p < NPAT; p++) begin
      n_vec++; if (pat_o !== IN_W'(p) || busy_o !== 1'b1) begin
        n_err++; $display("FAIL held_no_restart got pat=%0d busy=%b want pat=%0d busy=1", pat_o, busy_o, p);
      end
      tick();
    end
    n_vec++; if (done_o !== 1'b1 || sig_o !== want || pass_o !== 1'b1) begin
      n_err++; $display("FAIL held_done got done=%b sig=%05h want done=1 sig=%05h", done_o, sig_o, want);
    end
    tick();
    n_vec++; if (done_o !== 1'b0 || busy_o !== 1'b1 || sig_o !== 19'h0 || pat_o !== 2'd0) begin
      n_err++; $display("FAIL held_restart got done=%b busy=%b sig=%05h pat=%0d want 0/1/00000/0",
        done_o, busy_o, sig_o, pat_o);
    end
    start_i = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    n_vec++; if (done_o !== 1'b1 || sig_o !== want) begin
      n_err++; $display("FAIL held_second_run got done=%b sig=%05h want 1/%05h", done_o, sig_o, want);
    end
  endtask

  initial begin
    for (int p = 0; p < NPAT; p++) resp_tab[p] = '0;
    test_reset();
    test_zero_resp();
    test_ones_resp();
    test_hold();
    test_random_netlist();
    test_mid_reset();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
